writeback_arbiter: RTL and testbench
====================================

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 Parameter: DEPTH, 4, number of entries in the load-result FIFO; SHALL be a power of two, 2 to 16.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 alu_valid  input  1  ALU result present this cycle.
REQ-005 alu_rd  input  5  ALU destination register.
REQ-006 alu_data  input  32  ALU result.
REQ-007 alu_ready  output  1  ALU result accepted this cycle (combinational).
REQ-008 mem_valid  input  1  load result present.
REQ-009 mem_rd  input  5  load destination register.
REQ-010 mem_data  input  32  load result.
REQ-011 mem_ready  output  1  load result accepted this cycle (combinational).
REQ-012 wr_ena  output  1  register file write enable (registered).
REQ-013 wr_addr  output  5  register file write address (registered).
REQ-014 wr_data  output  32  register file write data (registered).
REQ-015 byp_addr0, byp_addr1  input  5 each  operand addresses for bypass lookup.
REQ-016 byp_hit0, byp_hit1  output  1 each  pending write found for that address (combinational).
REQ-017 byp_data0, byp_data1  output  32 each  youngest pending data for that address.
REQ-018 pending  output  5  number of valid FIFO entries.

Function
REQ-019 A source transfer SHALL occur only when valid and ready are both high in the same cycle.
REQ-020 A transfer whose rd is 0 SHALL be accepted and discarded: no FIFO entry, no write, no bypass hit.
REQ-021 mem_ready SHALL be high exactly when pending < DEPTH and rst is low; a pop in the same cycle SHALL NOT free space for a push.
REQ-022 Each accepted load with rd != 0 SHALL be pushed at the FIFO tail in acceptance order.
REQ-023 Port arbitration each cycle, in priority order:
  (a) STARVE: FIFO non-empty and starve count = 7 -> pop the FIFO head; alu_ready = 0.
  (b) WAW: ALU valid with alu_rd matching any FIFO entry rd -> pop the FIFO head; alu_ready = 0.
  (c) ALU: ALU valid -> alu_ready = 1; write the ALU result if alu_rd != 0.
  (d) DRAIN: otherwise, if the FIFO is non-empty -> pop the FIFO head.
  (e) IDLE: no write.
REQ-024 alu_ready SHALL be 1 whenever neither (a) nor (b) holds, including when alu_valid = 0.
REQ-025 The selected write SHALL appear on wr_ena/wr_addr/wr_data in the next cycle (latency 1); wr_ena SHALL be 0 in cycles after no selection.
REQ-026 At most one register file write per cycle; wr_addr SHALL never be 0 when wr_ena = 1.
REQ-027 Starve count (3 bits):
  - increments when the FIFO is non-empty and case (c) writes;
  - clears on any FIFO pop or when the FIFO is empty;
  - otherwise holds.
REQ-028 Bypass for each port, address a != 0:
  - hit on the youngest matching FIFO entry (nearest the tail);
  - else on the output stage (wr_ena = 1 and wr_addr = a);
  - else byp_hit = 0 and byp_data = 0.
REQ-029 Bypass SHALL NOT see same-cycle alu_* or mem_* inputs.
REQ-030 Pointers SHALL wrap modulo DEPTH; pending SHALL equal pushes minus pops since reset.

Reset
REQ-031 While rst is high: alu_ready = 0, mem_ready = 0, and all inputs are ignored.
REQ-032 On a clock edge with rst high:
  - wr_ena, wr_addr and wr_data SHALL clear to 0;
  - the FIFO SHALL empty (pending = 0);
  - the starve count SHALL clear to 0;
  - reset mid-operation SHALL discard all queued entries without writing them.
REQ-033 The FIFO data storage need not be reset; stale data SHALL never reach any output.

Verification
REQ-034 The bench SHALL cover these directed scenarios:
  - Single ALU write: alu (rd = 5, data 0xDEADBEEF) -> next cycle wr_ena = 1, wr_addr = 5, wr_data = 0xDEADBEEF.
  - Load drain: 3 loads to rd 1, 2, 3 with no ALU traffic -> three consecutive writes 1, 2, 3 in order.
  - Full FIFO (DEPTH = 4): 4 loads pushed while the ALU is continuously valid -> mem_ready = 0 and pending = 4.
  - Starvation: continued ALU traffic after a load is queued -> after 7 ALU writes, alu_ready = 0 for one cycle and the FIFO head is written.
  - WAW: load to rd 9 (0x11) queued, then ALU to rd 9 (0x22) -> the load is written first, alu_ready = 0 until then, and 0x22 is the final value; byp_addr0 = 9 returns 0x11 while the load is queued.
  - x0 and reset: alu rd = 0 produces no write; rst asserted with 2 entries queued -> pending = 0 and no writes afterward.

Source files
------------

// File: rtl/writeback_arbiter_if.sv
// Writeback arbiter bus bundle: ALU and load result sources, register file
// write port, operand bypass lookup and FIFO occupancy.
interface writeback_arbiter_if;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;

    logic        mem_valid;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        mem_ready;

    logic        wr_ena;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;

    logic [4:0]  byp_addr0;
    logic [4:0]  byp_addr1;
    logic        byp_hit0;
    logic        byp_hit1;
    logic [31:0] byp_data0;
    logic [31:0] byp_data1;

    logic [4:0]  pending;

    // Arbiter side.
    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  mem_valid, mem_rd, mem_data,
        input  byp_addr0, byp_addr1,
        output alu_ready, mem_ready,
        output wr_ena, wr_addr, wr_data,
        output byp_hit0, byp_hit1, byp_data0, byp_data1,
        output pending
    );

    // Pipeline side driving results and reading the write port.
    modport master (
        output alu_valid, alu_rd, alu_data,
        output mem_valid, mem_rd, mem_data,
        output byp_addr0, byp_addr1,
        input  alu_ready, mem_ready,
        input  wr_ena, wr_addr, wr_data,
        input  byp_hit0, byp_hit1, byp_data0, byp_data1,
        input  pending
    );
endinterface

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges ALU results and queued load results onto a single
// register file write port. Loads wait in a small FIFO; the ALU normally wins,
// but a write-after-write hazard or a starved FIFO forces the FIFO head out.
// Bypass lookups see the FIFO (youngest entry first) and the output stage.
module writeback_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    writeback_arbiter_if.slave bus
);
    localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] DEPTH_C = 5'(DEPTH);

    logic [4:0]    fifo_rd   [DEPTH];
    logic [31:0]   fifo_data [DEPTH];
    logic [AW-1:0] head_q;
    logic [AW-1:0] tail_q;
    logic [4:0]    count_q;
    logic [2:0]    starve_q;

    logic          wr_ena_q;
    logic [4:0]    wr_addr_q;
    logic [31:0]   wr_data_q;

    logic          fifo_empty;
    logic          waw_match;
    logic          starve_sel;
    logic          waw_sel;
    logic          alu_sel;
    logic          drain_sel;
    logic          pop;
    logic          push;
    logic          alu_wr;
    logic          mem_ready;
    logic          alu_ready;
    logic [AW-1:0] age;

    logic [4:0]    byp_addr [2];
    logic          byp_hit  [2];
    logic [31:0]   byp_data [2];
    logic [AW-1:0] byp_slot;

    // Occupancy of each slot and WAW detection against the queued loads.
    always_comb begin
        age       = '0;
        waw_match = 1'b0;
        for (int s = 0; s < DEPTH; s++) begin
            age = AW'(s) - head_q;
            if ((5'(age) < count_q) && (fifo_rd[s] == bus.alu_rd))
                waw_match = 1'b1;
        end
    end

    // Port arbitration in priority order: starve, WAW, ALU, drain.
    always_comb begin
        fifo_empty = (count_q == 5'd0);
        starve_sel = !rst && !fifo_empty && (starve_q == 3'd7);
        waw_sel    = !rst && !starve_sel && bus.alu_valid && waw_match;
        alu_sel    = !rst && !starve_sel && !waw_sel && bus.alu_valid;
        drain_sel  = !rst && !starve_sel && !waw_sel && !bus.alu_valid && !fifo_empty;
        pop        = starve_sel || waw_sel || drain_sel;
        alu_wr     = alu_sel && (bus.alu_rd != 5'd0);
        alu_ready  = !rst && !starve_sel && !waw_sel;
        // A pop in the same cycle deliberately does not make room for a push.
        mem_ready  = !rst && (count_q < DEPTH_C);
        push       = bus.mem_valid && mem_ready && (bus.mem_rd != 5'd0);
    end

    // Pointers, occupancy, starve counter and the registered write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            starve_q  <= '0;
            wr_ena_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            if (push)
                tail_q <= tail_q + AW'(1);
            if (pop)
                head_q <= head_q + AW'(1);
            count_q <= count_q + 5'(push) - 5'(pop);

            if (pop || fifo_empty)
                starve_q <= '0;
            else if (alu_wr)
                starve_q <= starve_q + 3'd1;

            if (pop) begin
                wr_ena_q  <= 1'b1;
                wr_addr_q <= fifo_rd[head_q];
                wr_data_q <= fifo_data[head_q];
            end else if (alu_wr) begin
                wr_ena_q  <= 1'b1;
                wr_addr_q <= bus.alu_rd;
                wr_data_q <= bus.alu_data;
            end else begin
                wr_ena_q  <= 1'b0;
            end
        end
    end

    // FIFO storage is left unreset; occupancy masks stale slots everywhere.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[tail_q]   <= bus.mem_rd;
            fifo_data[tail_q] <= bus.mem_data;
        end
    end

    // Bypass: walk oldest to youngest so the youngest match wins, then fall
    // back to the output stage.
    always_comb begin
        byp_addr[0] = bus.byp_addr0;
        byp_addr[1] = bus.byp_addr1;
        byp_slot    = '0;
        for (int p = 0; p < 2; p++) begin
            byp_hit[p]  = 1'b0;
            byp_data[p] = '0;
            for (int k = 0; k < DEPTH; k++) begin
                byp_slot = head_q + AW'(k);
                if ((5'(k) < count_q) && (byp_addr[p] != 5'd0) &&
                    (fifo_rd[byp_slot] == byp_addr[p])) begin
                    byp_hit[p]  = 1'b1;
                    byp_data[p] = fifo_data[byp_slot];
                end
            end
            if (!byp_hit[p] && (byp_addr[p] != 5'd0) && wr_ena_q &&
                (wr_addr_q == byp_addr[p])) begin
                byp_hit[p]  = 1'b1;
                byp_data[p] = wr_data_q;
            end
        end
    end

    // Drive the bus outputs.
    always_comb begin
        bus.alu_ready = alu_ready;
        bus.mem_ready = mem_ready;
        bus.wr_ena    = wr_ena_q;
        bus.wr_addr   = wr_addr_q;
        bus.wr_data   = wr_data_q;
        bus.byp_hit0  = byp_hit[0];
        bus.byp_hit1  = byp_hit[1];
        bus.byp_data0 = byp_data[0];
        bus.byp_data1 = byp_data[1];
        bus.pending   = count_q;
    end
endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter (DEPTH = 4): a per-cycle vector table
// followed by hand-written full-FIFO/starvation and reset sequences.
module tb_writeback_arbiter;
    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;

    writeback_arbiter_if bus ();

    writeback_arbiter #(.DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        av;
        logic [4:0]  ard;
        logic [31:0] ad;
        logic        mv;
        logic [4:0]  mrd;
        logic [31:0] md;
        logic [4:0]  b0;
        logic [4:0]  b1;
        logic        ar;
        logic        mr;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  pend;
        logic        h0;
        logic [31:0] d0;
        logic        h1;
        logic [31:0] d1;
    } vec_t;

    vec_t vecs [24];

    function automatic vec_t mk(int r, int av, int ard, int ad, int mv, int mrd, int md,
                                int b0, int b1, int ar, int mr, int we, int wa, int wd,
                                int pend, int h0, int d0, int h1, int d1);
        vec_t v;
        v.rst  = (r != 0);
        v.av   = (av != 0);
        v.ard  = 5'(ard);
        v.ad   = ad;
        v.mv   = (mv != 0);
        v.mrd  = 5'(mrd);
        v.md   = md;
        v.b0   = 5'(b0);
        v.b1   = 5'(b1);
        v.ar   = (ar != 0);
        v.mr   = (mr != 0);
        v.we   = (we != 0);
        v.wa   = 5'(wa);
        v.wd   = wd;
        v.pend = 5'(pend);
        v.h0   = (h0 != 0);
        v.d0   = d0;
        v.h1   = (h1 != 0);
        v.d1   = d1;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        rst           = v.rst;
        bus.alu_valid = v.av;
        bus.alu_rd    = v.ard;
        bus.alu_data  = v.ad;
        bus.mem_valid = v.mv;
        bus.mem_rd    = v.mrd;
        bus.mem_data  = v.md;
        bus.byp_addr0 = v.b0;
        bus.byp_addr1 = v.b1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_pass  = 0;
        n_total = 0;

        // rst | alu v,rd,data | mem v,rd,data | byp a0,a1 || ar mr we wa wd pend | h0 d0 h1 d1
        vecs[0]  = mk(1, 1,  5, 32'hDEADBEEF, 1, 7, 'h77,  0,  0,  0,0,0, 0,0,0,  0,0,0,0);
        vecs[1]  = mk(0, 1,  5, 32'hDEADBEEF, 0, 0, 0,     5,  0,  1,1,0, 0,0,0,  0,0,0,0);
        vecs[2]  = mk(0, 0,  0, 0,            0, 0, 0,     5,  6,  1,1,1, 5,32'hDEADBEEF,0, 1,32'hDEADBEEF,0,0);
        vecs[3]  = mk(0, 0,  0, 0,            1, 1, 'h101, 5,  0,  1,1,0, 0,0,0,  0,0,0,0);
        vecs[4]  = mk(0, 0,  0, 0,            1, 2, 'h202, 1,  0,  1,1,0, 0,0,1,  1,'h101,0,0);
        vecs[5]  = mk(0, 0,  0, 0,            1, 3, 'h303, 1,  2,  1,1,1, 1,'h101,1, 1,'h101,1,'h202);
        vecs[6]  = mk(0, 0,  0, 0,            0, 0, 0,     3,  0,  1,1,1, 2,'h202,1, 1,'h303,0,0);
        vecs[7]  = mk(0, 0,  0, 0,            0, 0, 0,     3,  0,  1,1,1, 3,'h303,0, 1,'h303,0,0);
        vecs[8]  = mk(0, 0,  0, 0,            0, 0, 0,     0,  0,  1,1,0, 0,0,0,  0,0,0,0);
        vecs[9]  = mk(0, 1,  0, 'h55,         0, 0, 0,     0,  0,  1,1,0, 0,0,0,  0,0,0,0);
        vecs[10] = mk(0, 0,  0, 0,            1, 0, 'h66,  0,  0,  1,1,0, 0,0,0,  0,0,0,0);
        vecs[11] = mk(0, 0,  0, 0,            0, 0, 0,     0,  0,  1,1,0, 0,0,0,  0,0,0,0);
        vecs[12] = mk(0, 0,  0, 0,            1, 9, 'h11,  0,  0,  1,1,0, 0,0,0,  0,0,0,0);
        vecs[13] = mk(0, 1,  9, 'h22,         0, 0, 0,     9,  0,  0,1,0, 0,0,1,  1,'h11,0,0);
        vecs[14] = mk(0, 1,  9, 'h22,         0, 0, 0,     9,  0,  1,1,1, 9,'h11,0, 1,'h11,0,0);
        vecs[15] = mk(0, 0,  0, 0,            0, 0, 0,     9,  0,  1,1,1, 9,'h22,0, 1,'h22,0,0);
        vecs[16] = mk(0, 0,  0, 0,            0, 0, 0,     0,  0,  1,1,0, 0,0,0,  0,0,0,0);
        vecs[17] = mk(0, 0,  0, 0,            1, 4, 'hA1,  0,  0,  1,1,0, 0,0,0,  0,0,0,0);
        vecs[18] = mk(0, 1, 10, 'hB0,         1, 4, 'hA2,  4,  0,  1,1,0, 0,0,1,  1,'hA1,0,0);
        vecs[19] = mk(0, 1, 11, 'hB1,         0, 0, 0,     4, 10,  1,1,1,10,'hB0,2, 1,'hA2,1,'hB0);
        vecs[20] = mk(0, 0,  0, 0,            0, 0, 0,     4,  0,  1,1,1,11,'hB1,2, 1,'hA2,0,0);
        vecs[21] = mk(0, 0,  0, 0,            0, 0, 0,     4,  0,  1,1,1, 4,'hA1,1, 1,'hA2,0,0);
        vecs[22] = mk(0, 0,  0, 0,            0, 0, 0,     4,  0,  1,1,1, 4,'hA2,0, 1,'hA2,0,0);
        vecs[23] = mk(0, 0,  0, 0,            0, 0, 0,     0,  0,  1,1,0, 0,0,0,  0,0,0,0);

        apply(mk(1, 0,0,0, 0,0,0, 0,0, 0,0,0,0,0,0, 0,0,0,0));
        repeat (2) @(negedge clk);
        #1;
        chk("reset_state",
            128'({bus.alu_ready, bus.mem_ready, bus.wr_ena, bus.wr_addr, bus.wr_data, bus.pending}),
            128'({1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 5'd0}));

        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            apply(vecs[i]);
            #1;
            chk($sformatf("vec%0d", i),
                128'({bus.alu_ready, bus.mem_ready, bus.wr_ena,
                      bus.wr_ena ? bus.wr_addr : 5'd0, bus.wr_ena ? bus.wr_data : 32'd0,
                      bus.pending, bus.byp_hit0, bus.byp_data0, bus.byp_hit1, bus.byp_data1}),
                128'({vecs[i].ar, vecs[i].mr, vecs[i].we, vecs[i].wa, vecs[i].wd,
                      vecs[i].pend, vecs[i].h0, vecs[i].d0, vecs[i].h1, vecs[i].d1}));
        end

        // Four loads under continuous ALU traffic: fill, starve, then drain.
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            apply(mk(0, (i <= 9) ? 1 : 0, 20 + i, 'hE0 + i, (i < 4) ? 1 : 0, 12 + i, 'hC0 + i,
                     0, 0, 0,0,0,0,0,0, 0,0,0,0));
            #1;
            if (i < 4)
                chk($sformatf("fill%0d", i), 128'(bus.pending), 128'(5'(i)));
            if (i == 4)
                chk("full", 128'({bus.mem_ready, bus.alu_ready, bus.pending}),
                    128'({1'b0, 1'b1, 5'd4}));
            if (i == 8)
                chk("starve_block", 128'({bus.alu_ready, bus.wr_ena, bus.wr_addr}),
                    128'({1'b0, 1'b1, 5'd27}));
            if (i == 9)
                chk("starve_write",
                    128'({bus.alu_ready, bus.wr_ena, bus.wr_addr, bus.wr_data, bus.pending}),
                    128'({1'b1, 1'b1, 5'd12, 32'hC0, 5'd3}));
            if (i >= 11 && i <= 13)
                chk($sformatf("drain%0d", i),
                    128'({bus.wr_ena, bus.wr_addr, bus.wr_data, bus.pending}),
                    128'({1'b1, 5'(i + 2), 32'('hC0 + i - 10), 5'(13 - i)}));
        end

        // Two loads queued behind ALU traffic, then reset mid-operation.
        for (int j = 0; j < 7; j++) begin
            @(negedge clk);
            if (j == 0)
                apply(mk(0, 1, 21, 'hF1, 1, 16, 'hD0, 0, 0, 0,0,0,0,0,0, 0,0,0,0));
            else if (j == 1)
                apply(mk(0, 1, 22, 'hF2, 1, 17, 'hD1, 0, 0, 0,0,0,0,0,0, 0,0,0,0));
            else if (j == 2)
                apply(mk(1, 1, 23, 'hF3, 1, 18, 'hD2, 0, 0, 0,0,0,0,0,0, 0,0,0,0));
            else
                apply(mk(0, 0, 0, 0, 0, 0, 0, 16, 17, 0,0,0,0,0,0, 0,0,0,0));
            #1;
            if (j == 2)
                chk("rst_hold", 128'({bus.alu_ready, bus.mem_ready, bus.pending}),
                    128'({1'b0, 1'b0, 5'd2}));
            if (j >= 3)
                chk($sformatf("rst_after%0d", j),
                    128'({bus.wr_ena, bus.pending, bus.byp_hit0, bus.byp_hit1}),
                    128'({1'b0, 5'd0, 1'b0, 1'b0}));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
